// File: rtl/neuron_delta_pkg.sv
// Shared constants and helpers for the neuron delta (backward) stage.
package neuron_delta_pkg;

  // TRAIN/TEST mode encoding shared by every stage of the network.
  typedef enum logic {
    MODE_TRAIN = 1'b0,
    MODE_TEST  = 1'b1
  } mode_e;

  // Width of one forward-state lane: hidden layers carry the activation,
  // the output layer carries the full pre-activation accumulator.
  function automatic int unsigned state_width(bit hidden, int unsigned np, int unsigned wf);
    return hidden ? wf : $clog2(np) + wf;
  endfunction

endpackage

// File: rtl/neuron_delta_if.sv
// Stream bundle of the delta stage: forward-state input, error input, delta output.
interface neuron_delta_if
  import neuron_delta_pkg::*;
#(
  parameter int unsigned NC = 4,
  parameter int unsigned WN = 4,
  parameter int unsigned WD = 8
);

  mode_e               iMode;

  logic                iValid_AM_State1;
  logic                oReady_AM_State1;
  logic [NC*WN-1:0]    iData_AM_State1;

  logic                iValid_AM_Delta0;
  logic                oReady_AM_Delta0;
  logic [NC*WD-1:0]    iData_AM_Delta0;

  logic                oValid_BM_Delta0;
  logic                iReady_BM_Delta0;
  logic [NC*WD-1:0]    oData_BM_Delta0;

  // Design side.
  modport slave (
    input  iMode,
    input  iValid_AM_State1, iData_AM_State1,
    output oReady_AM_State1,
    input  iValid_AM_Delta0, iData_AM_Delta0,
    output oReady_AM_Delta0,
    output oValid_BM_Delta0, oData_BM_Delta0,
    input  iReady_BM_Delta0
  );

  // Environment side.
  modport master (
    output iMode,
    output iValid_AM_State1, iData_AM_State1,
    input  oReady_AM_State1,
    output iValid_AM_Delta0, iData_AM_Delta0,
    input  oReady_AM_Delta0,
    input  oValid_BM_Delta0, oData_BM_Delta0,
    output iReady_BM_Delta0
  );

endinterface

// File: rtl/state_fifo.sv
// Synchronous state buffer; occupancy is registered, so a pushed entry is
// visible through empty_o/rdata_o only from the following cycle.
module state_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !clr_i;
  assign pop_ok  = pop_i && !empty_o && !clr_i;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers: reset and mode-clear both empty the buffer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/neuron_delta.sv
// Backward delta stage: buffers forward states, joins each with the incoming
// error beat and registers the per-lane delta toward the previous layer.
module neuron_delta
  import neuron_delta_pkg::*;
#(
  parameter string       HIDDEN = "yes",
  parameter int unsigned NP     = 4,
  parameter int unsigned NC     = 4,
  parameter int unsigned WF     = 4,
  parameter int unsigned WD     = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic           iCLK,
  input  logic           iRST,
  neuron_delta_if.slave  bus
);

  localparam int unsigned WN = state_width(HIDDEN == "yes", NP, WF);

  logic                 train;
  logic                 out_free;
  logic                 fire_join;
  logic                 push;
  logic                 fifo_full, fifo_empty;
  logic [NC*WN-1:0]     fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                 unused_count;
  logic [NC*WD-1:0]     oData_d;
  logic [NC*WD-1:0]     oData_q;
  logic                 oValid_q;

  assign train    = (bus.iMode == MODE_TRAIN);
  assign out_free = !oValid_q || bus.iReady_BM_Delta0;

  // In TEST the state port keeps accepting so the forward pass never stalls;
  // those beats are simply not written.
  assign bus.oReady_AM_State1 = iRST && (!train || !fifo_full);
  assign bus.oReady_AM_Delta0 = iRST && train && !fifo_empty && out_free;

  assign push      = train && bus.iValid_AM_State1 && bus.oReady_AM_State1;
  assign fire_join = bus.iValid_AM_Delta0 && bus.oReady_AM_Delta0;

  assign unused_count = ^fifo_count;

  state_fifo #(
    .WIDTH (NC*WN),
    .DEPTH (DEPTH)
  ) u_state_fifo (
    .clk_i   (iCLK),
    .rst_ni  (iRST),
    .clr_i   (!train),
    .push_i  (push),
    .pop_i   (fire_join),
    .wdata_i (bus.iData_AM_State1),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  for (genvar i = 0; i < NC; i++) begin : g_lane
    logic [WN-1:0] st;
    logic [WD-1:0] er;
    assign st = fifo_rdata[i*WN +: WN];
    assign er = bus.iData_AM_Delta0[i*WD +: WD];

    if (HIDDEN == "yes") begin : g_relu
      localparam logic [WN-1:0] CLIP = WN'((1 << (WF-1)) - 1);
      // ReLU derivative: zero where the activation was cut off or clipped.
      assign oData_d[i*WD +: WD] = (st == '0 || st == CLIP) ? '0 : er;
    end else begin : g_err
      // Target is taken at full lane width so large targets saturate.
      localparam int unsigned WS = ((WN > WD) ? WN : WD) + 1;
      localparam logic signed [WS-1:0] SMAX = WS'((1 << (WD-1)) - 1);
      localparam logic signed [WS-1:0] SMIN = WS'(-(1 << (WD-1)));
      logic signed [WS-1:0] st_x, er_x, diff;
      assign st_x = {{(WS-WN){st[WN-1]}}, st};
      assign er_x = {{(WS-WD){er[WD-1]}}, er};
      assign diff = st_x - er_x;
      assign oData_d[i*WD +: WD] = (diff > SMAX) ? SMAX[WD-1:0] :
                                   (diff < SMIN) ? SMIN[WD-1:0] : diff[WD-1:0];
    end
  end

  // Output register: load on join, release on a handshake with no new join.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      oValid_q <= 1'b0;
      oData_q  <= '0;
    end else if (fire_join) begin
      oValid_q <= 1'b1;
      oData_q  <= oData_d;
    end else if (bus.iReady_BM_Delta0) begin
      oValid_q <= 1'b0;
    end
  end

  assign bus.oValid_BM_Delta0 = oValid_q;
  assign bus.oData_BM_Delta0  = oData_q;

endmodule

// File: tb/tb_neuron_delta.sv
// Bench for neuron_delta: one hidden-layer and one output-layer instance,
// directed scenarios followed by random traffic against a queue model.
module tb_neuron_delta;
  import neuron_delta_pkg::*;

  localparam int unsigned NC = 2, WF = 4, NP = 4, WD = 8, DEPTH = 8;
  localparam int unsigned WNH = 4, WNO = 6;

  logic  clk = 1'b0;
  logic  rst_n;
  mode_e mode;
  always #5 clk = ~clk;

  neuron_delta_if #(.NC(NC), .WN(WNH), .WD(WD)) bh ();
  neuron_delta_if #(.NC(NC), .WN(WNO), .WD(WD)) bo ();

  neuron_delta #(.HIDDEN("yes"), .NP(NP), .NC(NC), .WF(WF), .WD(WD), .DEPTH(DEPTH))
    dut_h (.iCLK(clk), .iRST(rst_n), .bus(bh));
  neuron_delta #(.HIDDEN("no"), .NP(NP), .NC(NC), .WF(WF), .WD(WD), .DEPTH(DEPTH))
    dut_o (.iCLK(clk), .iRST(rst_n), .bus(bo));

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Reference state: buffered states in arrival order and the output slot.
  logic [NC*WNH-1:0] qh[$];
  logic [NC*WNO-1:0] qo[$];
  logic              ovh = 1'b0, ovo = 1'b0;
  logic [NC*WD-1:0]  odh = '0, odo = '0;
  logic [NC*WD-1:0]  hold_v;

  function automatic logic [NC*WD-1:0] exp_h(logic [NC*WNH-1:0] st, logic [NC*WD-1:0] er);
    logic [NC*WD-1:0] r;
    int s;
    for (int i = 0; i < NC; i++) begin
      s = int'(st[i*WNH +: WNH]);
      r[i*WD +: WD] = (s == 0 || s == (2**(WF-1) - 1)) ? 8'd0 : er[i*WD +: WD];
    end
    return r;
  endfunction

  function automatic logic [NC*WD-1:0] exp_o(logic [NC*WNO-1:0] st, logic [NC*WD-1:0] tg);
    logic [NC*WD-1:0] r;
    int s, t, d;
    for (int i = 0; i < NC; i++) begin
      s = $signed(st[i*WNO +: WNO]);
      t = $signed(tg[i*WD +: WD]);
      d = s - t;
      if (d > 127)  d = 127;
      if (d < -128) d = -128;
      r[i*WD +: WD] = d[7:0];
    end
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    total++;
    assert (act === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: compare outputs with the model, advance the model, tick.
  task automatic cycle();
    logic es, ed, fire, psh;
    bh.iMode = mode;
    bo.iMode = mode;
    #1;
    // hidden-layer instance
    es = !rst_n ? 1'b0 : (mode == MODE_TEST) ? 1'b1 : (qh.size() < DEPTH);
    ed = rst_n && mode == MODE_TRAIN && qh.size() > 0 && (!ovh || bh.iReady_BM_Delta0);
    check("h_rdy_state", bh.oReady_AM_State1, es);
    check("h_rdy_err",   bh.oReady_AM_Delta0, ed);
    check("h_valid",     bh.oValid_BM_Delta0, ovh);
    check("h_data",      bh.oData_BM_Delta0, odh);
    if (!rst_n) begin
      qh.delete(); ovh = 1'b0; odh = '0;
    end else if (mode == MODE_TEST) begin
      qh.delete();
      if (bh.iReady_BM_Delta0) ovh = 1'b0;
    end else begin
      fire = bh.iValid_AM_Delta0 && ed;
      psh  = bh.iValid_AM_State1 && es;
      if (fire) begin
        odh = exp_h(qh.pop_front(), bh.iData_AM_Delta0);
        ovh = 1'b1;
      end else if (bh.iReady_BM_Delta0) ovh = 1'b0;
      if (psh) qh.push_back(bh.iData_AM_State1);
    end
    // output-layer instance
    es = !rst_n ? 1'b0 : (mode == MODE_TEST) ? 1'b1 : (qo.size() < DEPTH);
    ed = rst_n && mode == MODE_TRAIN && qo.size() > 0 && (!ovo || bo.iReady_BM_Delta0);
    check("o_rdy_state", bo.oReady_AM_State1, es);
    check("o_rdy_err",   bo.oReady_AM_Delta0, ed);
    check("o_valid",     bo.oValid_BM_Delta0, ovo);
    check("o_data",      bo.oData_BM_Delta0, odo);
    if (!rst_n) begin
      qo.delete(); ovo = 1'b0; odo = '0;
    end else if (mode == MODE_TEST) begin
      qo.delete();
      if (bo.iReady_BM_Delta0) ovo = 1'b0;
    end else begin
      fire = bo.iValid_AM_Delta0 && ed;
      psh  = bo.iValid_AM_State1 && es;
      if (fire) begin
        odo = exp_o(qo.pop_front(), bo.iData_AM_Delta0);
        ovo = 1'b1;
      end else if (bo.iReady_BM_Delta0) ovo = 1'b0;
      if (psh) qo.push_back(bo.iData_AM_State1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    mode  = MODE_TRAIN;
    bh.iValid_AM_State1 = 1'b0; bh.iData_AM_State1 = '0;
    bh.iValid_AM_Delta0 = 1'b0; bh.iData_AM_Delta0 = '0;
    bh.iReady_BM_Delta0 = 1'b1;
    bo.iValid_AM_State1 = 1'b0; bo.iData_AM_State1 = '0;
    bo.iValid_AM_Delta0 = 1'b0; bo.iData_AM_Delta0 = '0;
    bo.iReady_BM_Delta0 = 1'b1;
    @(negedge clk);
    cycle();
    cycle();
    check("rst_valid", bh.oValid_BM_Delta0, 1'b0);
    check("rst_data",  bh.oData_BM_Delta0, 16'h0000);
    rst_n = 1'b1;

    // Same-cycle state and error into an empty buffer: join waits a cycle.
    bh.iValid_AM_State1 = 1'b1; bh.iData_AM_State1 = {4'd3, 4'd0};
    bh.iValid_AM_Delta0 = 1'b1; bh.iData_AM_Delta0 = {8'hFC, 8'd10};
    bo.iValid_AM_State1 = 1'b1; bo.iData_AM_State1 = {6'h22, 6'd20};
    bo.iValid_AM_Delta0 = 1'b1; bo.iData_AM_Delta0 = {8'd100, 8'h88};
    check("nojoin_same_cycle", bh.oReady_AM_Delta0, 1'b0);
    cycle();
    check("no_early_valid", bh.oValid_BM_Delta0, 1'b0);
    bh.iData_AM_State1 = {4'd5, 4'd7};
    bo.iValid_AM_State1 = 1'b0;
    cycle();
    check("relu_beat0", bh.oData_BM_Delta0, 16'hFC00);
    check("relu_valid", bh.oValid_BM_Delta0, 1'b1);
    check("sat_beat",   bo.oData_BM_Delta0, 16'h807F);
    bh.iValid_AM_State1 = 1'b0;
    bh.iData_AM_Delta0  = {8'd6, 8'd6};
    bo.iValid_AM_Delta0 = 1'b0;
    cycle();
    check("relu_beat1", bh.oData_BM_Delta0, 16'h0600);
    bh.iValid_AM_Delta0 = 1'b0;
    cycle();
    cycle();

    // Fill the buffer, free one slot, then the ninth state gets in.
    bh.iValid_AM_State1 = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bh.iData_AM_State1 = 8'($urandom);
      cycle();
    end
    check("full_not_ready", bh.oReady_AM_State1, 1'b0);
    bh.iData_AM_State1  = 8'($urandom);
    bh.iValid_AM_Delta0 = 1'b1; bh.iData_AM_Delta0 = 16'($urandom);
    cycle();
    bh.iValid_AM_Delta0 = 1'b0;
    check("ready_after_pop", bh.oReady_AM_State1, 1'b1);
    cycle();
    bh.iValid_AM_State1 = 1'b0;

    // Stalled output: one beat held, later errors wait, then drain in order.
    bh.iReady_BM_Delta0 = 1'b0;
    bh.iValid_AM_Delta0 = 1'b1; bh.iData_AM_Delta0 = 16'h0A05;
    cycle();
    hold_v = odh;
    bh.iData_AM_Delta0 = 16'hF30C;
    repeat (4) cycle();
    check("stall_hold", bh.oData_BM_Delta0, hold_v);
    bh.iReady_BM_Delta0 = 1'b1;
    cycle();
    check("drain_valid", bh.oValid_BM_Delta0, 1'b1);
    bh.iData_AM_Delta0 = 16'h7F81;
    cycle();
    bh.iValid_AM_Delta0 = 1'b0;
    cycle();
    cycle();

    // Reset with states buffered and a pending beat.
    bh.iReady_BM_Delta0 = 1'b0;
    bh.iValid_AM_Delta0 = 1'b1; bh.iData_AM_Delta0 = 16'h1234;
    cycle();
    check("pending_before_rst", bh.oValid_BM_Delta0, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    bh.iReady_BM_Delta0 = 1'b1;
    check("rst_clears_valid", bh.oValid_BM_Delta0, 1'b0);
    check("rst_empties_fifo", bh.oReady_AM_Delta0, 1'b0);
    repeat (3) cycle();
    bh.iValid_AM_State1 = 1'b1; bh.iData_AM_State1 = {4'd2, 4'd1};
    cycle();
    bh.iValid_AM_State1 = 1'b0;
    cycle();
    bh.iValid_AM_Delta0 = 1'b0;
    cycle();

    // TEST mode: drops states, blocks errors, lets the pending beat drain.
    bh.iReady_BM_Delta0 = 1'b0;
    bh.iValid_AM_State1 = 1'b1; bh.iData_AM_State1 = {4'd4, 4'd6};
    cycle();
    bh.iValid_AM_Delta0 = 1'b1; bh.iData_AM_Delta0 = 16'h2233;
    cycle();
    mode = MODE_TEST;
    cycle();
    bh.iReady_BM_Delta0 = 1'b1;
    cycle();
    cycle();
    mode = MODE_TRAIN;
    bh.iValid_AM_State1 = 1'b0;
    cycle();
    check("train_starts_empty", bh.oReady_AM_Delta0, 1'b0);
    bh.iValid_AM_Delta0 = 1'b0;

    // Random traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      mode  = ($urandom_range(0, 29) == 0) ? MODE_TEST : MODE_TRAIN;
      bh.iValid_AM_State1 = ($urandom_range(0, 3) != 0);
      bh.iData_AM_State1  = 8'($urandom);
      bh.iValid_AM_Delta0 = ($urandom_range(0, 3) != 0);
      bh.iData_AM_Delta0  = 16'($urandom);
      bh.iReady_BM_Delta0 = ($urandom_range(0, 3) != 0);
      bo.iValid_AM_State1 = ($urandom_range(0, 3) != 0);
      bo.iData_AM_State1  = 12'($urandom);
      bo.iValid_AM_Delta0 = ($urandom_range(0, 3) != 0);
      bo.iData_AM_Delta0  = 16'($urandom);
      bo.iReady_BM_Delta0 = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
